// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl -- two-button stopwatch controller.
//
// Both raw buttons are synchronized, debounced and turned into one-cycle
// press events. A small FSM (IDLE / RUN / STOP / LAP) walks the stopwatch
// through its modes. A prescaler produces the counter TICK while running.
// A one-cycle CLR zeroes the external time counter when the user clears
// from STOP.
//
// Parameters:
//   P_DEB_CYCLES : stable cycles needed before a button level is accepted
//   P_TICK_DIV   : CLK1 cycles per TICK (2 or more)
//
// Ports:
//   CLK1      in   single clock, rising edge
//   RST_N     in   synchronous active-low reset
//   BTN_SS_N  in   raw active-low start/stop button (asynchronous)
//   BTN_LAP_N in   raw active-low lap/clear button (asynchronous)
//   TICK      out  one-cycle pulse advancing the time counter
//   CLR       out  one-cycle pulse zeroing the time counter
//   HOLD      out  level freezing the display latch while in LAP
//   STATE     out  00 IDLE, 01 RUN, 10 STOP, 11 LAP
//
// Build option:
//   STOPWATCH_CTRL_LAP_EN  when defined, the LAP state and HOLD are built.
//                          When undefined, LAP presses in RUN are ignored,
//                          HOLD is tied low and STATE never reaches 11.
// ---------------------------------------------------------------------------

// Synchronizer + debouncer + press detector for one active-low button.
//   CLK1   in   clock
//   RST_N  in   synchronous active-low reset
//   btn_n  in   raw active-low button
//   press  out  one-cycle pulse on each accepted press (debounced 1->0)
module stopwatch_ctrl_deb #(
    parameter int P_DEB_CYCLES = 500000
) (
    input  logic CLK1,
    input  logic RST_N,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (P_DEB_CYCLES > 1) ? $clog2(P_DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(P_DEB_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]    flush_q;
    logic          armed_q;

    // armed_q blocks press events until the button has been seen released
    // after reset, so a button held through reset does not fire when its
    // debounced level eventually drops. flush_q waits out the synchronizer,
    // whose reset value of 1 would otherwise look like a release.
    always_ff @(posedge CLK1) begin
        if (!RST_N) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            level_q <= 1'b1;
            level_d <= 1'b1;
            cnt_q   <= '0;
            flush_q <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync_q1 <= btn_n;
            sync_q2 <= sync_q1;
            level_d <= level_q;
            flush_q <= {flush_q[0], 1'b1};

            if (flush_q[1] && sync_q2) begin
                armed_q <= 1'b1;
            end

            // Any cycle where the input agrees with the accepted level
            // restarts the stability count.
            if (sync_q2 == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level_q <= sync_q2;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press = level_d & ~level_q & armed_q;

endmodule

module stopwatch_ctrl #(
    parameter int P_DEB_CYCLES = 500000,
    parameter int P_TICK_DIV   = 500000
) (
    input  logic       CLK1,
    input  logic       RST_N,
    input  logic       BTN_SS_N,
    input  logic       BTN_LAP_N,
    output logic       TICK,
    output logic       CLR,
    output logic       HOLD,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STOP = 2'b10,
        S_LAP  = 2'b11
    } state_t;

    localparam int PW = (P_TICK_DIV > 1) ? $clog2(P_TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(P_TICK_DIV - 1);

    state_t        state_q;
    logic          clr_q;
    logic [PW-1:0] presc_q;
    logic          ss_press;
    logic          lap_press;
    logic          running;
`ifdef STOPWATCH_CTRL_LAP_EN
    logic          hold_q;
`endif

    stopwatch_ctrl_deb #(
        .P_DEB_CYCLES (P_DEB_CYCLES)
    ) u_deb_ss (
        .CLK1  (CLK1),
        .RST_N (RST_N),
        .btn_n (BTN_SS_N),
        .press (ss_press)
    );

    stopwatch_ctrl_deb #(
        .P_DEB_CYCLES (P_DEB_CYCLES)
    ) u_deb_lap (
        .CLK1  (CLK1),
        .RST_N (RST_N),
        .btn_n (BTN_LAP_N),
        .press (lap_press)
    );

    // The time base keeps counting in LAP; only the display is frozen.
    assign running = (state_q == S_RUN) || (state_q == S_LAP);

    // Mode FSM plus prescaler. SS is tested first in every state, so a
    // same-cycle LAP event is simply dropped. The prescaler is left alone
    // in STOP so a resume finishes the interrupted interval.
    always_ff @(posedge CLK1) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            clr_q   <= 1'b0;
            presc_q <= '0;
`ifdef STOPWATCH_CTRL_LAP_EN
            hold_q  <= 1'b0;
`endif
        end else begin
            clr_q <= 1'b0;

            if (running) begin
                if (presc_q == PRE_MAX) begin
                    presc_q <= '0;
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (ss_press) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (ss_press) begin
                        state_q <= S_STOP;
                    end
`ifdef STOPWATCH_CTRL_LAP_EN
                    else if (lap_press) begin
                        state_q <= S_LAP;
                        hold_q  <= 1'b1;
                    end
`endif
                end
`ifdef STOPWATCH_CTRL_LAP_EN
                S_LAP: begin
                    if (ss_press) begin
                        state_q <= S_STOP;
                        hold_q  <= 1'b0;
                    end else if (lap_press) begin
                        state_q <= S_RUN;
                        hold_q  <= 1'b0;
                    end
                end
`endif
                S_STOP: begin
                    if (ss_press) begin
                        state_q <= S_RUN;
                    end else if (lap_press) begin
                        state_q <= S_IDLE;
                        clr_q   <= 1'b1;
                        presc_q <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign TICK  = running && (presc_q == PRE_MAX);
    assign CLR   = clr_q;
    assign STATE = state_q;
`ifdef STOPWATCH_CTRL_LAP_EN
    assign HOLD  = hold_q;
`else
    assign HOLD  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl -- self-checking bench for stopwatch_ctrl with
// P_DEB_CYCLES=4 and P_TICK_DIV=10. Inputs are driven and outputs sampled
// 1 time unit after the falling edge. Expected values are pushed to exp_q
// when stimulus is applied and popped when the DUT response is observed.
// The LAP scenario adapts to whether STOPWATCH_CTRL_LAP_EN is defined.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int DEB = 4;
    localparam int DIV = 10;
    localparam int LAT = DEB + 3;

    logic       CLK1      = 1'b0;
    logic       RST_N     = 1'b0;
    logic       BTN_SS_N  = 1'b1;
    logic       BTN_LAP_N = 1'b1;
    logic       TICK;
    logic       CLR;
    logic       HOLD;
    logic [1:0] STATE;

    int n_cmp    = 0;
    int n_err    = 0;
    int tick_cnt = 0;
    int clr_cnt  = 0;

    logic [31:0] exp_q[$];

    stopwatch_ctrl #(
        .P_DEB_CYCLES (DEB),
        .P_TICK_DIV   (DIV)
    ) dut (
        .CLK1      (CLK1),
        .RST_N     (RST_N),
        .BTN_SS_N  (BTN_SS_N),
        .BTN_LAP_N (BTN_LAP_N),
        .TICK      (TICK),
        .CLR       (CLR),
        .HOLD      (HOLD),
        .STATE     (STATE)
    );

    // ---------------- clock ----------------
    always #5 CLK1 = ~CLK1;

    // Pulse counters, sampled on the falling edge.
    always @(negedge CLK1) begin
        if (TICK) tick_cnt++;
        if (CLR)  clr_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK1);
            #1;
        end
    endtask

    // Press the selected buttons for 'hold' cycles, report the first state
    // change (cycles after the raw edge, -1 if none) and CLR/HOLD on that
    // cycle, then release and let the release settle.
    task automatic drive_press(input bit ss, input bit lap, input int hold,
                               output int lat, output logic [1:0] st,
                               output logic clr_at, output logic hold_at);
        logic [1:0] st0;
        st0     = STATE;
        lat     = -1;
        st      = STATE;
        clr_at  = 1'b0;
        hold_at = HOLD;
        if (ss)  BTN_SS_N  = 1'b0;
        if (lap) BTN_LAP_N = 1'b0;
        for (int i = 1; i <= hold; i++) begin
            step(1);
            if (lat < 0 && STATE !== st0) begin
                lat     = i;
                st      = STATE;
                clr_at  = CLR;
                hold_at = HOLD;
            end
        end
        BTN_SS_N  = 1'b1;
        BTN_LAP_N = 1'b1;
        step(10);
    endtask

    // Wait (bounded) until a TICK is observed; counts a failure on timeout.
    task automatic wait_tick(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3 * DIV && !found; i++) begin
            step(1);
            if (TICK === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL %s: no TICK within %0d cycles (required one)", name, 3 * DIV);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int t0;
        RST_N = 1'b0;
        step(5);
        RST_N = 1'b1;
        step(1);
        n_cmp++; if (STATE !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b want 00", STATE); end
        n_cmp++; if (TICK !== 1'b0)   begin n_err++; $display("FAIL reset_tick: got %b want 0", TICK); end
        n_cmp++; if (CLR !== 1'b0)    begin n_err++; $display("FAIL reset_clr: got %b want 0", CLR); end
        n_cmp++; if (HOLD !== 1'b0)   begin n_err++; $display("FAIL reset_hold: got %b want 0", HOLD); end
        t0 = tick_cnt;
        step(8);
        n_cmp++; if (tick_cnt - t0 !== 0) begin n_err++; $display("FAIL idle_no_tick: got %0d ticks want 0", tick_cnt - t0); end
    endtask

    task automatic test_run();
        int lat;
        int obs_q[$];
        int o;
        logic [31:0] e;
        lat = -1;
        exp_q.push_back(LAT);
        BTN_SS_N = 1'b0;
        for (int i = 1; i <= 120; i++) begin
            step(1);
            if (i == 20) BTN_SS_N = 1'b1;
            if (lat < 0 && STATE === 2'b01) lat = i;
            if (lat >= 0 && (i - lat) < 100 && TICK === 1'b1) obs_q.push_back(i - lat);
        end
        e = exp_q.pop_front();
        n_cmp++; if (lat !== int'(e)) begin n_err++; $display("FAIL run_latency: got %0d want %0d", lat, e); end
        for (int k = 0; k < 10; k++) exp_q.push_back(32'(DIV * k + DIV - 1));
        n_cmp++; if (obs_q.size() !== 10) begin n_err++; $display("FAIL run_tick_count: got %0d want 10", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            n_cmp++;
            if (o !== int'(e)) begin n_err++; $display("FAIL run_tick_offset: got %0d want %0d", o, e); end
        end
    endtask

    task automatic test_pause_resume();
        int stop_at, tick_at, stop_ticks, bad, run_at, first_tick;
        logic [31:0] e;
        stop_at = -1; tick_at = -1; stop_ticks = 0; bad = 0; run_at = -1; first_tick = -1;
        wait_tick("pause_align");
        step(6);
        // Raw edge 6 cycles after a tick: the next tick still lands in RUN
        // 4 cycles later, and STOP begins 3 cycles after that tick.
        exp_q.push_back(4);
        exp_q.push_back(LAT);
        BTN_SS_N = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            step(1);
            if (i == 10) BTN_SS_N = 1'b1;
            if (stop_at < 0 && STATE === 2'b10) stop_at = i;
            if (stop_at < 0 && tick_at < 0 && TICK === 1'b1) tick_at = i;
            if (stop_at >= 0) begin
                if (TICK !== 1'b0) stop_ticks++;
                if (STATE !== 2'b10) bad++;
            end
        end
        e = exp_q.pop_front();
        n_cmp++; if (tick_at !== int'(e)) begin n_err++; $display("FAIL pause_last_tick: got %0d want %0d", tick_at, e); end
        e = exp_q.pop_front();
        n_cmp++; if (stop_at !== int'(e)) begin n_err++; $display("FAIL pause_latency: got %0d want %0d", stop_at, e); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL pause_state_held: got %0d bad cycles want 0", bad); end
        exp_q.push_back(LAT);
        exp_q.push_back(7);
        BTN_SS_N = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (i == 12) BTN_SS_N = 1'b1;
            if (run_at < 0 && STATE === 2'b01) run_at = i;
            if (run_at < 0 && TICK !== 1'b0) stop_ticks++;
            if (run_at >= 0 && first_tick < 0 && TICK === 1'b1) first_tick = i - run_at;
        end
        n_cmp++; if (stop_ticks !== 0) begin n_err++; $display("FAIL stop_no_tick: got %0d ticks want 0", stop_ticks); end
        e = exp_q.pop_front();
        n_cmp++; if (run_at !== int'(e)) begin n_err++; $display("FAIL resume_latency: got %0d want %0d", run_at, e); end
        e = exp_q.pop_front();
        n_cmp++; if (first_tick !== int'(e)) begin n_err++; $display("FAIL resume_first_tick: got %0d want %0d", first_tick, e); end
    endtask

    task automatic test_bounce();
        int bad_b, bad_g;
        bad_b = 0; bad_g = 0;
        for (int i = 0; i < 20; i++) begin
            BTN_SS_N = ((i / 2) % 2 == 1) ? 1'b1 : 1'b0;
            step(1);
            if (STATE !== 2'b01) bad_b++;
        end
        BTN_SS_N = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (STATE !== 2'b01) bad_b++;
        end
        n_cmp++; if (bad_b !== 0) begin n_err++; $display("FAIL bounce_no_event: got %0d changed cycles want 0", bad_b); end
        BTN_SS_N = 1'b0;
        for (int i = 0; i < 18; i++) begin
            step(1);
            if (i == 2) BTN_SS_N = 1'b1;
            if (STATE !== 2'b01) bad_g++;
        end
        n_cmp++; if (bad_g !== 0) begin n_err++; $display("FAIL glitch_no_event: got %0d changed cycles want 0", bad_g); end
    endtask

    task automatic test_simultaneous();
        int lat, bad, c0;
        logic [1:0] st;
        logic clr_at, hold_at;
        logic [31:0] e;
        bad = 0;
        c0 = clr_cnt;
        // In RUN: SS wins, LAP is discarded.
        exp_q.push_back(LAT);
        exp_q.push_back(2'b10);
        drive_press(1'b1, 1'b1, 15, lat, st, clr_at, hold_at);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== int'(e)) begin n_err++; $display("FAIL simul_run_latency: got %0d want %0d", lat, e); end
        e = exp_q.pop_front();
        n_cmp++; if (st !== e[1:0]) begin n_err++; $display("FAIL simul_run_state: got %b want %b", st, e[1:0]); end
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (STATE !== 2'b10 || HOLD !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL simul_lap_discarded: got %0d bad cycles want 0", bad); end
        // In STOP: SS wins again, so RUN rather than a clear.
        exp_q.push_back(2'b01);
        drive_press(1'b1, 1'b1, 15, lat, st, clr_at, hold_at);
        e = exp_q.pop_front();
        n_cmp++; if (st !== e[1:0]) begin n_err++; $display("FAIL simul_stop_state: got %b want %b", st, e[1:0]); end
        n_cmp++; if (clr_cnt - c0 !== 0) begin n_err++; $display("FAIL simul_no_clr: got %0d pulses want 0", clr_cnt - c0); end
    endtask

`ifdef STOPWATCH_CTRL_LAP_EN
    task automatic test_lap();
        int lat, bad, t0;
        logic [1:0] st;
        logic clr_at, hold_at;
        logic [31:0] e;
        bad = 0;
        exp_q.push_back(LAT);
        exp_q.push_back(2'b11);
        drive_press(1'b0, 1'b1, 15, lat, st, clr_at, hold_at);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== int'(e)) begin n_err++; $display("FAIL lap_latency: got %0d want %0d", lat, e); end
        e = exp_q.pop_front();
        n_cmp++; if (st !== e[1:0]) begin n_err++; $display("FAIL lap_state: got %b want %b", st, e[1:0]); end
        n_cmp++; if (hold_at !== 1'b1) begin n_err++; $display("FAIL lap_hold_on: got %b want 1", hold_at); end
        t0 = tick_cnt;
        for (int i = 0; i < 3 * DIV; i++) begin
            step(1);
            if (STATE !== 2'b11 || HOLD !== 1'b1) bad++;
        end
        n_cmp++; if (tick_cnt - t0 !== 3) begin n_err++; $display("FAIL lap_ticks_continue: got %0d want 3", tick_cnt - t0); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL lap_held: got %0d bad cycles want 0", bad); end
        exp_q.push_back(2'b01);
        drive_press(1'b0, 1'b1, 15, lat, st, clr_at, hold_at);
        e = exp_q.pop_front();
        n_cmp++; if (st !== e[1:0]) begin n_err++; $display("FAIL lap_back_state: got %b want %b", st, e[1:0]); end
        n_cmp++; if (hold_at !== 1'b0) begin n_err++; $display("FAIL lap_hold_off: got %b want 0", hold_at); end
        wait_tick("lap_stop_align");
        step(1);
        exp_q.push_back(2'b10);
        drive_press(1'b1, 1'b0, 15, lat, st, clr_at, hold_at);
        e = exp_q.pop_front();
        n_cmp++; if (st !== e[1:0]) begin n_err++; $display("FAIL lap_stop_state: got %b want %b", st, e[1:0]); end
    endtask
`else
    task automatic test_lap_off();
        int lat, bad;
        logic [1:0] st;
        logic clr_at, hold_at;
        logic [31:0] e;
        bad = 0;
        exp_q.push_back(32'hFFFF_FFFF);
        BTN_LAP_N = 1'b0;
        drive_press(1'b0, 1'b1, 15, lat, st, clr_at, hold_at);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== int'(e)) begin n_err++; $display("FAIL lapoff_no_change: got %0d want %0d", lat, int'(e)); end
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (STATE !== 2'b01 || HOLD !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL lapoff_run_held: got %0d bad cycles want 0", bad); end
        wait_tick("lapoff_stop_align");
        step(1);
        exp_q.push_back(2'b10);
        drive_press(1'b1, 1'b0, 15, lat, st, clr_at, hold_at);
        e = exp_q.pop_front();
        n_cmp++; if (st !== e[1:0]) begin n_err++; $display("FAIL lapoff_stop_state: got %b want %b", st, e[1:0]); end
    endtask
`endif

    task automatic test_clear();
        int lat, c0, t0, run_at, first_tick;
        logic [1:0] st;
        logic clr_at, hold_at;
        logic [31:0] e;
        run_at = -1; first_tick = -1;
        c0 = clr_cnt;
        exp_q.push_back(LAT);
        exp_q.push_back(2'b00);
        exp_q.push_back(1);
        drive_press(1'b0, 1'b1, 15, lat, st, clr_at, hold_at);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== int'(e)) begin n_err++; $display("FAIL clear_latency: got %0d want %0d", lat, e); end
        e = exp_q.pop_front();
        n_cmp++; if (st !== e[1:0]) begin n_err++; $display("FAIL clear_state: got %b want %b", st, e[1:0]); end
        e = exp_q.pop_front();
        n_cmp++; if (clr_at !== e[0]) begin n_err++; $display("FAIL clear_coincident: got %b want %b", clr_at, e[0]); end
        n_cmp++; if (clr_cnt - c0 !== 1) begin n_err++; $display("FAIL clear_one_pulse: got %0d want 1", clr_cnt - c0); end
        // LAP in IDLE is ignored and must not clear again.
        t0 = tick_cnt;
        drive_press(1'b0, 1'b1, 15, lat, st, clr_at, hold_at);
        n_cmp++; if (STATE !== 2'b00) begin n_err++; $display("FAIL idle_lap_ignored: got %b want 00", STATE); end
        n_cmp++; if (tick_cnt - t0 !== 0 || clr_cnt - c0 !== 1) begin
            n_err++; $display("FAIL idle_quiet: got %0d ticks %0d clr want 0 ticks 1 clr", tick_cnt - t0, clr_cnt - c0);
        end
        exp_q.push_back(LAT);
        exp_q.push_back(DIV - 1);
        BTN_SS_N = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (i == 15) BTN_SS_N = 1'b1;
            if (run_at < 0 && STATE === 2'b01) run_at = i;
            if (run_at >= 0 && first_tick < 0 && TICK === 1'b1) first_tick = i - run_at;
        end
        e = exp_q.pop_front();
        n_cmp++; if (run_at !== int'(e)) begin n_err++; $display("FAIL restart_latency: got %0d want %0d", run_at, e); end
        e = exp_q.pop_front();
        n_cmp++; if (first_tick !== int'(e)) begin n_err++; $display("FAIL restart_first_tick: got %0d want %0d", first_tick, e); end
    endtask

    task automatic test_reset_midop();
        int lat, bad, c0;
        logic [1:0] st;
        logic clr_at, hold_at;
        logic [31:0] e;
        bad = 0;
        c0 = clr_cnt;
        BTN_SS_N = 1'b0;
        step(2);
        RST_N = 1'b0;
        step(1);
        n_cmp++; if (STATE !== 2'b00 || CLR !== 1'b0) begin
            n_err++; $display("FAIL midop_reset: got state %b clr %b want 00 0", STATE, CLR);
        end
        step(2);
        RST_N = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (STATE !== 2'b00) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL held_through_reset: got %0d changed cycles want 0", bad); end
        n_cmp++; if (clr_cnt - c0 !== 0) begin n_err++; $display("FAIL midop_no_clr: got %0d pulses want 0", clr_cnt - c0); end
        BTN_SS_N = 1'b1;
        step(12);
        exp_q.push_back(LAT);
        exp_q.push_back(2'b01);
        drive_press(1'b1, 1'b0, 15, lat, st, clr_at, hold_at);
        e = exp_q.pop_front();
        n_cmp++; if (lat !== int'(e)) begin n_err++; $display("FAIL repress_latency: got %0d want %0d", lat, e); end
        e = exp_q.pop_front();
        n_cmp++; if (st !== e[1:0]) begin n_err++; $display("FAIL repress_state: got %b want %b", st, e[1:0]); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_run();
        test_pause_resume();
        test_bounce();
        test_simultaneous();
`ifdef STOPWATCH_CTRL_LAP_EN
        test_lap();
`else
        test_lap_off();
`endif
        test_clear();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
